// File: rtl/pwr_evt_pkg.sv
// Shared types, default cycle counts and timer-width helper for the power-event initiator.
package pwr_evt_pkg;

    typedef enum logic [2:0] {
        OFF       = 3'd0,
        PRESS     = 3'd1,
        WAIT_ON   = 3'd2,
        ON        = 3'd3,
        FORCE_OFF = 3'd4
    } pwr_evt_state_t;

    localparam int DEF_DEBOUNCE_CYC   = 1024;
    localparam int DEF_PULSE_CYC      = 6554;
    localparam int DEF_FORCE_OFF_CYC  = 131072;
    localparam int DEF_ON_TIMEOUT_CYC = 327680;

    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

    // Width whose range strictly exceeds max_count.
    function automatic int cnt_width(input int max_count);
        return $clog2(max_count + 1);
    endfunction

endpackage

// File: rtl/pwr_evt_debounce.sv
// Two-flop synchronizer plus stability counter: the output follows the input
// only after DEBOUNCE_CYC consecutive synchronized samples at the new level.
module pwr_evt_debounce
    import pwr_evt_pkg::*;
#(
    parameter int   DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
    parameter logic RST_VAL      = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic level,
    output logic stable
);

    localparam int CW = cnt_width(DEBOUNCE_CYC);

    logic          sync_p0;
    logic          sync_p1;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_p0 <= RST_VAL;
            sync_p1 <= RST_VAL;
        end else begin
            sync_p0 <= level;
            sync_p1 <= sync_p0;
        end
    end

    // Any sample matching the current level restarts the qualification run.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            stable <= RST_VAL;
        end else if (sync_p1 == stable) begin
            cnt <= '0;
        end else if (cnt == CW'(DEBOUNCE_CYC - 1)) begin
            stable <= sync_p1;
            cnt    <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/pwr_event_gen.sv
// Power-event initiator in the suspend clock domain: button debounce, PCH power-button
// pulse, power-on request and forced shutdown. Optional macro PWR_EVT_AC_RESTORE_EN.
module pwr_event_gen
    import pwr_evt_pkg::*;
#(
    parameter int DEBOUNCE_CYC   = DEF_DEBOUNCE_CYC,
    parameter int PULSE_CYC      = DEF_PULSE_CYC,
    parameter int FORCE_OFF_CYC  = DEF_FORCE_OFF_CYC,
    parameter int ON_TIMEOUT_CYC = DEF_ON_TIMEOUT_CYC,
    parameter int CNT_W          = cnt_width(max4(DEBOUNCE_CYC, PULSE_CYC,
                                                  FORCE_OFF_CYC, ON_TIMEOUT_CYC))
) (
    input  logic       CLK_33K_SUSCLK_PLD_R2,
    input  logic       RST_RSMRST_N,
    input  logic       FP_PWR_BTN_IN_N,
    input  logic       FM_BMC_PWR_BTN_N,
    input  logic       FM_SLPS3_N,
    input  logic       FM_SLPS4_N,
    input  logic       PWRGD_PS_PWROK_3V3,
    output logic       FM_PCH_PWRBTN_N,
    output logic       PsonFromPwrEvent,
    output logic       PwrEvtFault,
    output logic [2:0] PwrEvtState
);

    logic clk;
    logic rst_n;
    assign clk   = CLK_33K_SUSCLK_PLD_R2;
    assign rst_n = RST_RSMRST_N;

    // Bit order {pwrok, slps4_n, slps3_n, bmc_btn_n}; BMC idles released (high).
    localparam logic [3:0] SYNC_RST = 4'b0001;

    logic [3:0]     sync_p0;
    logic [3:0]     sync_p1;
    logic           fp_stable_n;
    logic           btn;
    logic           btn_q;
    logic           press_edge;
    logic           ac_fire;
    logic           fault_nxt;
    logic [CNT_W-1:0] timer;
    pwr_evt_state_t state;
    pwr_evt_state_t state_nxt;

    pwr_evt_debounce #(
        .DEBOUNCE_CYC (DEBOUNCE_CYC),
        .RST_VAL      (1'b1)
    ) u_fp_debounce (
        .clk    (clk),
        .rst_n  (rst_n),
        .level  (FP_PWR_BTN_IN_N),
        .stable (fp_stable_n)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_p0 <= SYNC_RST;
            sync_p1 <= SYNC_RST;
        end else begin
            sync_p0 <= {PWRGD_PS_PWROK_3V3, FM_SLPS4_N, FM_SLPS3_N, FM_BMC_PWR_BTN_N};
            sync_p1 <= sync_p0;
        end
    end

    assign btn        = ~fp_stable_n | ~sync_p1[0];
    assign press_edge = btn & ~btn_q;

`ifdef PWR_EVT_AC_RESTORE_EN
    // Counts the first edges after reset; fires exactly once on the third.
    logic [1:0] ac_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ac_cnt <= 2'd0;
        end else if (ac_cnt != 2'd3) begin
            ac_cnt <= ac_cnt + 2'd1;
        end
    end

    assign ac_fire = (ac_cnt == 2'd2);
`else
    assign ac_fire = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        fault_nxt = PwrEvtFault;
        case (state)
            OFF: begin
                if (press_edge || ac_fire) begin
                    state_nxt = PRESS;
                    fault_nxt = 1'b0;
                end
            end
            PRESS: begin
                if (timer == CNT_W'(PULSE_CYC - 1)) state_nxt = WAIT_ON;
            end
            WAIT_ON: begin
                if (sync_p1[1] && sync_p1[3]) begin
                    state_nxt = ON;
                end else if (timer == CNT_W'(ON_TIMEOUT_CYC - 1)) begin
                    state_nxt = OFF;
                    fault_nxt = 1'b1;
                end
            end
            ON: begin
                if (!sync_p1[1] || !sync_p1[2]) begin
                    state_nxt = OFF;
                end else if (btn && (timer == CNT_W'(FORCE_OFF_CYC - 1))) begin
                    state_nxt = FORCE_OFF;
                end
            end
            FORCE_OFF: begin
                if (!btn) state_nxt = OFF;
            end
            default: state_nxt = OFF;
        endcase
    end

    // In ON the shared timer measures the current continuous hold of the button.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= OFF;
            timer            <= '0;
            btn_q            <= 1'b0;
            FM_PCH_PWRBTN_N  <= 1'b1;
            PsonFromPwrEvent <= 1'b0;
            PwrEvtFault      <= 1'b0;
        end else begin
            btn_q       <= btn;
            state       <= state_nxt;
            PwrEvtFault <= fault_nxt;
            if (state_nxt != state) begin
                timer <= '0;
            end else if ((state == ON) && !btn) begin
                timer <= '0;
            end else if (timer != {CNT_W{1'b1}}) begin
                timer <= timer + 1'b1;
            end
            FM_PCH_PWRBTN_N  <= !((state_nxt == PRESS) || ((state_nxt == ON) && btn));
            PsonFromPwrEvent <= (state_nxt == PRESS) || (state_nxt == WAIT_ON) ||
                                (state_nxt == ON);
        end
    end

    assign PwrEvtState = state;

endmodule

// File: tb/tb_pwr_event_gen.sv
// Directed bench for pwr_event_gen with a cycle-level reference model and literal checks.
module tb_pwr_event_gen;

    localparam int D  = 4;
    localparam int P  = 8;
    localparam int F  = 32;
    localparam int TO = 64;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       fp_n = 1'b1;
    logic       bmc_n = 1'b1;
    logic       s3_n = 1'b0;
    logic       s4_n = 1'b1;
    logic       pwrok = 1'b0;
    logic       pwrbtn_o;
    logic       pson_o;
    logic       fault_o;
    logic [2:0] state_o;

    int n_total = 0;
    int n_pass  = 0;
    int low_cnt = 0;

    pwr_event_gen #(
        .DEBOUNCE_CYC   (D),
        .PULSE_CYC      (P),
        .FORCE_OFF_CYC  (F),
        .ON_TIMEOUT_CYC (TO)
    ) dut (
        .CLK_33K_SUSCLK_PLD_R2 (clk),
        .RST_RSMRST_N          (rst_n),
        .FP_PWR_BTN_IN_N       (fp_n),
        .FM_BMC_PWR_BTN_N      (bmc_n),
        .FM_SLPS3_N            (s3_n),
        .FM_SLPS4_N            (s4_n),
        .PWRGD_PS_PWROK_3V3    (pwrok),
        .FM_PCH_PWRBTN_N       (pwrbtn_o),
        .PsonFromPwrEvent      (pson_o),
        .PwrEvtFault           (fault_o),
        .PwrEvtState           (state_o)
    );

    always #5 clk = ~clk;

    // Reference model: states 0..4 with dwell counts, debounce as run length of samples.
`ifdef PWR_EVT_AC_RESTORE_EN
    localparam bit AC_EN = 1'b1;
`else
    localparam bit AC_EN = 1'b0;
`endif

    logic [2:0] m_state, m_ns;
    bit m_pwrbtn, m_pson, m_fault;
    bit m_fp1, m_fp2, m_bmc1, m_bmc2, m_s31, m_s32, m_s41, m_s42, m_ok1, m_ok2;
    bit m_stab, m_last, m_btn_prev, m_btn, m_press;
    int m_run, m_cyc, m_dwell, m_held;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_state = 3'd0; m_pwrbtn = 1'b1; m_pson = 1'b0; m_fault = 1'b0;
            m_fp1 = 1'b1; m_fp2 = 1'b1; m_bmc1 = 1'b1; m_bmc2 = 1'b1;
            m_s31 = 1'b0; m_s32 = 1'b0; m_s41 = 1'b0; m_s42 = 1'b0;
            m_ok1 = 1'b0; m_ok2 = 1'b0;
            m_stab = 1'b1; m_last = 1'b1; m_run = 0; m_btn_prev = 1'b0;
            m_cyc = 0; m_dwell = 0; m_held = 0;
        end else begin
            m_cyc++;
            m_btn   = !m_stab || !m_bmc2;
            m_press = m_btn && !m_btn_prev;
            m_ns    = m_state;
            case (m_state)
                3'd0: if (m_press || (AC_EN && m_cyc == 3)) begin m_ns = 3'd1; m_fault = 1'b0; end
                3'd1: if (m_dwell == P - 1) m_ns = 3'd2;
                3'd2: begin
                    if (m_s32 && m_ok2) m_ns = 3'd3;
                    else if (m_dwell == TO - 1) begin m_ns = 3'd0; m_fault = 1'b1; end
                end
                3'd3: begin
                    m_held = m_btn ? m_held + 1 : 0;
                    if (!m_s32 || !m_s42) m_ns = 3'd0;
                    else if (m_held == F) m_ns = 3'd4;
                end
                3'd4: if (!m_btn) m_ns = 3'd0;
                default: m_ns = 3'd0;
            endcase
            if (m_ns != m_state) begin m_dwell = 0; m_held = 0; end
            else m_dwell++;
            m_state  = m_ns;
            m_pwrbtn = !(m_ns == 3'd1 || (m_ns == 3'd3 && m_btn));
            m_pson   = (m_ns == 3'd1) || (m_ns == 3'd2) || (m_ns == 3'd3);
            if (m_fp2 == m_last) m_run++;
            else begin m_run = 1; m_last = m_fp2; end
            if (m_fp2 != m_stab && m_run >= D) m_stab = m_fp2;
            m_fp2 = m_fp1;   m_fp1 = fp_n;
            m_bmc2 = m_bmc1; m_bmc1 = bmc_n;
            m_s32 = m_s31;   m_s31 = s3_n;
            m_s42 = m_s41;   m_s41 = s4_n;
            m_ok2 = m_ok1;   m_ok1 = pwrok;
            m_btn_prev = m_btn;
        end
    end

    task automatic chk(input string name, input int got, input int exp);
        n_total++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, required %0d", name, got, exp);
    endtask

    // Advance n cycles; each falling edge compares the DUT with the model.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (rst_n) begin
                n_total++;
                if ({state_o, pwrbtn_o, pson_o, fault_o} === {m_state, m_pwrbtn, m_pson, m_fault})
                    n_pass++;
                else
                    $display("FAIL model t=%0t st/btn_n/pson/flt got %0d/%0b/%0b/%0b required %0d/%0b/%0b/%0b",
                             $time, state_o, pwrbtn_o, pson_o, fault_o,
                             m_state, m_pwrbtn, m_pson, m_fault);
            end
            if (!pwrbtn_o) low_cnt++;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        step(3);
        chk("rst_pwrbtn_n", pwrbtn_o, 1);
        chk("rst_pson", pson_o, 0);
        chk("rst_fault", fault_o, 0);
        chk("rst_state", state_o, 0);
        rst_n = 1'b1;

`ifdef PWR_EVT_AC_RESTORE_EN
        step(2);
        chk("ac_state_c2", state_o, 0);
        step(1);
        chk("ac_state_c3", state_o, 1);
        step(90);
        chk("ac_timeout_state", state_o, 0);
        chk("ac_timeout_fault", fault_o, 1);
        step(10);
        chk("ac_once", state_o, 0);
`endif

        // Glitch shorter than the debounce window.
        step(2);
        low_cnt = 0;
        fp_n = 1'b0; step(3); fp_n = 1'b1;
        step(12);
        chk("glitch_state", state_o, 0);
        chk("glitch_low_cnt", low_cnt, 0);

        // Valid press: exact pulse length, then power comes up.
        low_cnt = 0;
        fp_n = 1'b0; step(10); fp_n = 1'b1;
        step(20);
        chk("pulse_low_cnt", low_cnt, P);
        chk("wait_on_state", state_o, 2);
        chk("wait_on_pson", pson_o, 1);
        s3_n = 1'b1; s4_n = 1'b1; pwrok = 1'b1;
        step(4);
        chk("on_state", state_o, 3);

        // Long hold in ON: pass-through, then forced off, no re-power on release.
        fp_n = 1'b0; step(20);
        chk("hold_pass_state", state_o, 3);
        chk("hold_pass_btn_n", pwrbtn_o, 0);
        step(20); fp_n = 1'b1;
        chk("force_state", state_o, 4);
        chk("force_pson", pson_o, 0);
        chk("force_btn_n", pwrbtn_o, 1);
        step(15);
        chk("release_off", state_o, 0);
        step(20);
        chk("no_repower", state_o, 0);
        chk("no_repower_pson", pson_o, 0);

        // Power-on timeout with SLP_S3# held low, then a press clears the fault.
        s3_n = 1'b0; pwrok = 1'b0;
        step(3);
        fp_n = 1'b0; step(10); fp_n = 1'b1;
        step(65);
        chk("to_wait_state", state_o, 2);
        step(15);
        chk("to_state", state_o, 0);
        chk("to_fault", fault_o, 1);
        chk("to_pson", pson_o, 0);
        fp_n = 1'b0; step(10); fp_n = 1'b1;
        chk("reclear_state", state_o, 1);
        chk("reclear_fault", fault_o, 0);
        s3_n = 1'b1; pwrok = 1'b1;
        step(30);
        chk("reon_state", state_o, 3);

        // SLP_S4# drop in ON.
        s4_n = 1'b0;
        step(2);
        chk("s4_before", state_o, 3);
        step(1);
        chk("s4_off", state_o, 0);
        s4_n = 1'b1;
        step(3);

        // BMC request (not debounced), then asynchronous reset mid-pulse.
        bmc_n = 1'b0; step(3); bmc_n = 1'b1;
        chk("bmc_press", state_o, 1);
        step(2);
        chk("bmc_pulse_btn_n", pwrbtn_o, 0);
        chk("bmc_pulse_pson", pson_o, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_btn_n", pwrbtn_o, 1);
        chk("async_rst_pson", pson_o, 0);
        chk("async_rst_state", state_o, 0);
        step(2);
        rst_n = 1'b1;
        step(1);
        chk("post_rst_state", state_o, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
